// File: rtl/fb_port_arbiter_pkg.sv
// Shared definitions for the frame-buffer port arbiter: slot encoding,
// read-pipeline depth and frame geometry.
package fb_port_arbiter_pkg;

    // What the single RAM port does in a given cycle.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        WRITE    = 2'd2,
        FORCE_WR = 2'd3
    } slot_e;

    // Cycles from rd_req to rd_data/rd_valid.
    localparam int READ_LAT = 3;

    // Frame-buffer geometry (160x120, one RGB444 pixel per word).
    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_PIXELS = 19200;

    // True for slots that consume the head of the write FIFO.
    function automatic logic slot_pops(input slot_e slot);
        return (slot == WRITE) || (slot == FORCE_WR);
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO that buffers camera writes until the arbiter
// finds a free RAM slot. DEPTH must be a power of two and at least 2.
// Pointers carry one extra MSB so that full and empty are distinguishable
// when the index bits match; wrap-around is plain binary overflow.
module fb_wr_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] store [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign head  = store[rd_ptr[IDX_W-1:0]];

    // Pointer update; reset empties the FIFO.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage.
    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever read after it has been written, and a resettable array costs
    // far more than it buys.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the single-port frame-buffer RAM between display reads (strict
// priority, fixed latency) and buffered camera writes (drained in idle
// slots). A starvation guard steals one read slot for a write when the
// write FIFO has been full for STARVE_LIM cycles; the displaced read is
// still answered on time, flagged with rd_miss and the previous pixel.
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // display read side
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_miss,
    // camera write side
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    // frame-buffer RAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // statistics
    input  logic              clr_stats,
    output logic [15:0]       ovf_count
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int SC_W    = $clog2(STARVE_LIM + 1);
    localparam int PIPE_W  = READ_LAT - 1;

    // ------------------------------------------------------------------
    // Write buffer
    // ------------------------------------------------------------------
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic               push;
    logic               pop;
    logic               drop;

    // No same-cycle bypass: a pop only frees space for the next cycle.
    // Gating with rst_n keeps wr_ready low for the whole reset period.
    assign wr_ready = rst_n && !fifo_full;
    assign push     = wr_valid && wr_ready;
    assign drop     = wr_valid && !wr_ready;

    assign {head_addr, head_data} = fifo_head;

    fb_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({wr_addr, wr_data}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // ------------------------------------------------------------------
    // Slot decision
    // ------------------------------------------------------------------
    logic [SC_W-1:0] starve_cnt;
    logic            starved;
    slot_e           slot;

    assign starved = (starve_cnt == SC_W'(STARVE_LIM)) && !fifo_empty;

    // Pick this cycle's RAM slot: forced write, then read, then drain.
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        slot = IDLE;
        if (starved)          slot = FORCE_WR;
        else if (rd_req)      slot = READ;
        else if (!fifo_empty) slot = WRITE;
    end

    assign pop = slot_pops(slot);

    // Count consecutive full-FIFO cycles with no pop, saturating at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (pop || !fifo_full) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SC_W'(STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RAM port: register the chosen slot onto the bus one cycle later
    // ------------------------------------------------------------------
    // Drive the RAM port; address/data hold through idle slots.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= (slot != IDLE);
            mem_we <= pop;
            unique case (slot)
                READ: begin
                    mem_addr <= rd_addr;
                end
                WRITE, FORCE_WR: begin
                    mem_addr  <= head_addr;
                    mem_wdata <= head_data;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read return pipeline
    // ------------------------------------------------------------------
    // Stage 0 lines up with the RAM bus cycle, stage PIPE_W-1 with the
    // cycle mem_rdata is valid; the output register is the last stage.
    logic [PIPE_W-1:0] iss_valid;
    logic [PIPE_W-1:0] iss_miss;
    logic [PIPE_W-1:0] valid_shift_in;
    logic [PIPE_W-1:0] miss_shift_in;

    if (PIPE_W > 1) begin : g_deep_pipe
        assign valid_shift_in = {iss_valid[PIPE_W-2:0], rd_req};
        assign miss_shift_in  = {iss_miss[PIPE_W-2:0], rd_req && (slot == FORCE_WR)};
    end else begin : g_short_pipe
        assign valid_shift_in = rd_req;
        assign miss_shift_in  = rd_req && (slot == FORCE_WR);
    end

    // Shift issue flags and capture returning pixels; reset squashes
    // anything in flight. A displaced read keeps the previous pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_valid <= '0;
            iss_miss  <= '0;
            rd_valid  <= 1'b0;
            rd_miss   <= 1'b0;
            rd_data   <= '0;
        end else begin
            iss_valid <= valid_shift_in;
            iss_miss  <= miss_shift_in;
            rd_valid  <= iss_valid[PIPE_W-1];
            rd_miss   <= iss_miss[PIPE_W-1];
            if (iss_valid[PIPE_W-1] && !iss_miss[PIPE_W-1]) begin
                rd_data <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Overflow statistics
    // ------------------------------------------------------------------
    // Saturating count of dropped camera pixels; a clear beats a drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (clr_stats) begin
            ovf_count <= '0;
        end else if (drop && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter. A behavioural RAM with 1-cycle
// read latency sits on the memory port; expected read results and RAM
// writes are queued when stimulus is driven and popped by monitors.
module tb_fb_port_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_miss;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              clr_stats;
    logic [15:0]       ovf_count;

    always #5 clk = ~clk;

    fb_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (4),
        .STARVE_LIM (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_miss   (rd_miss),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .clr_stats (clr_stats),
        .ovf_count (ovf_count)
    );

    // Behavioural single-port RAM, 1-cycle read latency.
    logic [DATA_W-1:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int          err_count   = 0;
    int          check_count = 0;
    bit          mon_en      = 1'b0;
    logic [12:0] exp_rd [$];
    logic [26:0] exp_wr [$];
    logic [12:0] mon_rd_e;
    logic [26:0] mon_wr_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        check_count++;
        if (got !== want) begin
            err_count++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_pix(input logic [ADDR_W-1:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req    = 1'b0;
        wr_valid  = 1'b0;
        clr_stats = 1'b0;
    endtask

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (rd_valid) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", 32'(rd_valid), 32'd0);
                end else begin
                    mon_rd_e = exp_rd.pop_front();
                    check("rd_result", {rd_miss, rd_data}, mon_rd_e);
                end
            end
            if (mem_en && mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 32'(mem_we), 32'd0);
                end else begin
                    mon_wr_e = exp_wr.pop_front();
                    check("wr_issue", {mem_addr, mem_wdata}, mon_wr_e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int drops;
        int iters;
        int w;

        for (int i = 0; i < 32768; i++) ram[i] = init_pix(ADDR_W'(i));
        ram[15'h0123] = 12'hABC;

        // Reset with both requesters active.
        rst_n     = 1'b0;
        rd_req    = 1'b1;
        rd_addr   = 15'h0123;
        wr_valid  = 1'b1;
        wr_addr   = 15'h0055;
        wr_data   = 12'hFFF;
        clr_stats = 1'b0;
        repeat (3) tick();
        check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);
        check("rst_rd", {rd_valid, rd_miss, rd_data}, 32'd0);
        check("rst_ovf", ovf_count, 32'd0);
        check("rst_wr_ready", wr_ready, 32'd0);

        rst_n  = 1'b1;
        idle_inputs();
        mon_en = 1'b1;
        tick();
        check("rel_wr_ready", wr_ready, 32'd1);
        check("rel_mem_en", mem_en, 32'd0);

        // Single read with fixed 3-cycle latency.
        rd_req  = 1'b1;
        rd_addr = 15'h0123;
        exp_rd.push_back({1'b0, 12'hABC});
        tick();
        check("rd_bus", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 15'h0123});
        rd_req = 1'b0;
        tick();
        check("rd_not_yet", rd_valid, 32'd0);
        tick();
        check("rd_lat", {rd_valid, rd_miss, rd_data}, {1'b1, 1'b0, 12'hABC});

        // Idle drain of three writes: three consecutive write slots.
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr  = ADDR_W'(5 + i);
            wr_data  = DATA_W'(1 + i);
            exp_wr.push_back({ADDR_W'(5 + i), DATA_W'(1 + i)});
            tick();
            if (i > 0) check("drain_we", {mem_en, mem_we}, 32'd3);
        end
        wr_valid = 1'b0;
        tick();
        check("drain_we", {mem_en, mem_we}, 32'd3);
        tick();
        check("drain_done", {mem_en, wr_ready}, 32'd1);

        // Read back a drained write.
        rd_req  = 1'b1;
        rd_addr = 15'd5;
        exp_rd.push_back({1'b0, 12'h001});
        tick();
        rd_req = 1'b0;
        repeat (3) tick();

        // Continuous reads with six back-to-back writes: four accepted,
        // two dropped, and after eight full cycles one forced write.
        for (int i = 0; i < 14; i++) begin
            rd_req   = 1'b1;
            rd_addr  = 15'h0200 + ADDR_W'(i);
            wr_valid = (i < 6);
            wr_addr  = 15'h0100 + ADDR_W'(i);
            wr_data  = 12'h010 + DATA_W'(i);
            if (i < 4) exp_wr.push_back({15'h0100 + ADDR_W'(i), 12'h010 + DATA_W'(i)});
            if (i == 12) exp_rd.push_back({1'b1, init_pix(15'h0200 + 15'd11)});
            else         exp_rd.push_back({1'b0, init_pix(15'h0200 + ADDR_W'(i))});
            tick();
            if (i == 11) check("pre_force_we", mem_we, 32'd0);
            if (i == 12) check("force_we", {mem_en, mem_we, mem_addr, mem_wdata},
                               {1'b1, 1'b1, 15'h0100, 12'h010});
        end
        idle_inputs();
        repeat (8) tick();
        check("ovf_two", ovf_count, 32'd2);
        check("force_done", {mem_en, wr_ready}, 32'd1);
        check("sb_empty_1", exp_rd.size() + exp_wr.size(), 32'd0);

        // Saturate the overflow counter (scoreboard paused).
        mon_en = 1'b0;
        drops  = 0;
        iters  = 0;
        while (drops < 70000 && iters < 85000) begin
            rd_req   = 1'b1;
            rd_addr  = 15'h0300;
            wr_valid = 1'b1;
            wr_addr  = 15'h0400;
            wr_data  = 12'h000;
            if (!wr_ready) drops++;
            iters++;
            tick();
        end
        check("sat_drops", 32'(drops >= 70000), 32'd1);
        check("ovf_sat", ovf_count, 32'hFFFF);

        // Clear coinciding with a drop: clear wins.
        w = 0;
        while (wr_ready && w < 20) begin
            tick();
            w++;
        end
        check("clr_setup", wr_ready, 32'd0);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_wins", ovf_count, 32'd0);

        idle_inputs();
        repeat (10) tick();
        exp_rd.delete();
        exp_wr.delete();
        mon_en = 1'b1;

        // Reset mid-operation: three FIFO entries, two reads in flight.
        wr_valid = 1'b1;
        wr_addr  = 15'h0500;
        wr_data  = 12'h050;
        tick();
        for (int i = 0; i < 2; i++) begin
            rd_req   = 1'b1;
            rd_addr  = 15'h0210 + ADDR_W'(i);
            wr_addr  = 15'h0501 + ADDR_W'(i);
            wr_data  = 12'h051 + DATA_W'(i);
            tick();
        end
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_quiet", {rd_valid, mem_en}, 32'd0);
        end
        check("post_rst_ready", wr_ready, 32'd1);

        // Normal operation resumes after the flush.
        rd_req  = 1'b1;
        rd_addr = 15'h0123;
        exp_rd.push_back({1'b0, 12'hABC});
        tick();
        rd_req = 1'b0;
        w = 0;
        while ((exp_rd.size() + exp_wr.size()) != 0 && w < 20) begin
            tick();
            w++;
        end
        check("sb_drained", exp_rd.size() + exp_wr.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
